// File: rtl/safety_island_boot_ctrl.sv
// Safety-island boot controller: samples bootmode after reset, sequences core fetch-enable,
// and exposes a small OBI register window (boot address, fetch enable, core status, mode, state).
//
// state     | meaning
// INIT      | first edge after reset, samples bootmode
// JTAG_WAIT | waiting for host FETCHEN write
// DELAY     | preloaded start-up delay running
// RUN       | core fetching, boot address frozen
// EOC       | software signalled end of computation (terminal)
// ERROR     | invalid bootmode sampled (terminal)
module safety_island_boot_ctrl #(
  parameter logic [31:0] BaseAddr        = 32'h0000_0000,
  parameter logic [31:0] BootAddrDefault = 32'h0000_1000,
  parameter int unsigned StartupDelay    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  bootmode_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] boot_addr_o,
  output logic        fetch_enable_o,
  output logic        eoc_o,
  output logic [30:0] exit_code_o,
  output logic        boot_err_o
);

  localparam int CntW = $clog2(StartupDelay + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(StartupDelay - 1);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_JTAG_WAIT = 3'd1,
    ST_DELAY     = 3'd2,
    ST_RUN       = 3'd3,
    ST_EOC       = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      bootmode_q;
  logic [31:0]     bootaddr_q;
  logic            launch;

  logic        acc_err;
  logic [31:0] rd_data;
  logic        sel_bootaddr, sel_fetchen, sel_status;
  logic        wr_ok, wr_bootaddr, wr_fetchen, wr_status;

  // The window is a 4 KiB aperture; upper address bits are decoded upstream.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:12], BaseAddr};

  assign gnt_o = req_i;

  always_comb begin
    acc_err      = 1'b0;
    rd_data      = 32'h0;
    sel_bootaddr = 1'b0;
    sel_fetchen  = 1'b0;
    sel_status   = 1'b0;
    if (addr_i[1:0] != 2'b00) begin
      acc_err = 1'b1;
    end else begin
      case (addr_i[11:2])
        10'd0: begin
          sel_bootaddr = 1'b1;
          rd_data      = bootaddr_q;
        end
        10'd1: begin
          sel_fetchen = 1'b1;
          rd_data     = {31'h0, fetch_enable_o};
        end
        10'd2: begin
          sel_status = 1'b1;
          rd_data    = {eoc_o, exit_code_o};
          if (we_i && be_i != 4'hF) acc_err = 1'b1;
        end
        10'd3: begin
          rd_data = {30'h0, bootmode_q};
          if (we_i) acc_err = 1'b1;
        end
        10'd4: begin
          rd_data = {29'h0, state_q};
          if (we_i) acc_err = 1'b1;
        end
        default: acc_err = 1'b1;
      endcase
    end
    if (acc_err || we_i) rd_data = 32'h0;
  end

  assign wr_ok       = req_i && we_i && !acc_err;
  assign wr_bootaddr = wr_ok && sel_bootaddr;
  assign wr_fetchen  = wr_ok && sel_fetchen && be_i[0] && wdata_i[0];
  assign wr_status   = wr_ok && sel_status;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        case (bootmode_i)
          2'b00: state_d = ST_JTAG_WAIT;
          2'b01: begin
            state_d = ST_DELAY;
            cnt_d   = '0;
          end
          default: state_d = ST_ERROR;
        endcase
      end
      ST_JTAG_WAIT: if (wr_fetchen) state_d = ST_RUN;
      ST_DELAY: begin
        if (cnt_q == CntLast) state_d = ST_RUN;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      ST_RUN: if (wr_status && wdata_i[31]) state_d = ST_EOC;
      default: state_d = state_q;
    endcase
    launch = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      bootmode_q     <= 2'b00;
      bootaddr_q     <= BootAddrDefault;
      boot_addr_o    <= BootAddrDefault;
      fetch_enable_o <= 1'b0;
      eoc_o          <= 1'b0;
      exit_code_o    <= '0;
      boot_err_o     <= 1'b0;
      rvalid_o       <= 1'b0;
      rdata_o        <= '0;
      err_o          <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      boot_err_o <= (state_d == ST_ERROR);
      if (state_q == ST_INIT) bootmode_q <= bootmode_i;
      if (wr_bootaddr) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) bootaddr_q[8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      // Preloaded boot always enters at the BootROM entry, whatever BOOTADDR holds.
      if (launch) begin
        boot_addr_o    <= (state_q == ST_JTAG_WAIT) ? bootaddr_q : BootAddrDefault;
        fetch_enable_o <= 1'b1;
      end
      if (state_q == ST_RUN && wr_status) begin
        exit_code_o <= wdata_i[30:0];
        if (wdata_i[31]) eoc_o <= 1'b1;
      end
      rvalid_o <= req_i;
      rdata_o  <= req_i ? rd_data : 32'h0;
      err_o    <= req_i && acc_err;
    end
  end

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Scoreboard bench for safety_island_boot_ctrl: expected OBI responses are queued at issue
// and matched when rvalid_o appears; boot sequencing is checked directly on the outputs.
module tb_safety_island_boot_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  bootmode_i = 2'b00;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] boot_addr_o;
  logic        fetch_enable_o;
  logic        eoc_o;
  logic [30:0] exit_code_o;
  logic        boot_err_o;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  safety_island_boot_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bootmode_i(bootmode_i),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .boot_addr_o(boot_addr_o), .fetch_enable_o(fetch_enable_o), .eoc_o(eoc_o),
    .exit_code_o(exit_code_o), .boot_err_o(boot_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 1, 0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rdata_o, e[31:0]);
        chk("rsp_err", err_o, e[32]);
      end
    end
  end

  task automatic obi(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    #1 chk("gnt", gnt_o, 1);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fetch"}, fetch_enable_o, 0);
    chk({tag, "_bootaddr"}, boot_addr_o, 32'h0000_1000);
    chk({tag, "_eoc"}, eoc_o, 0);
    chk({tag, "_exit"}, exit_code_o, 0);
    chk({tag, "_booterr"}, boot_err_o, 0);
    chk({tag, "_rvalid"}, rvalid_o, 0);
  endtask

  // Assert reset asynchronously mid low phase, check outputs, release on a falling edge.
  task automatic do_reset(input string tag, input logic [1:0] mode);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    bootmode_i = mode;
    #1 check_reset_vals(tag);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Counts rising edges after release until fetch_enable_o is seen high.
  task automatic wait_fetch(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      n++;
      if (fetch_enable_o) break;
    end
  endtask

  initial begin
    int n;
    // ---- Jtag boot ----
    do_reset("rst_jtag", 2'b00);
    repeat (2) @(posedge clk_i);
    bootmode_i = 2'b01;
    obi(0, 32'h10, 4'hF, 0, 32'd1, 0);
    obi(0, 32'h0C, 4'hF, 0, 32'd0, 0);
    obi(1, 32'h00, 4'hF, 32'h8000_0080, 0, 0);
    obi(1, 32'h04, 4'h0, 32'h1, 0, 0);
    chk("jtag_no_launch_be0", fetch_enable_o, 0);
    obi(1, 32'h04, 4'h1, 32'h1, 0, 0);
    chk("jtag_fetch", fetch_enable_o, 1);
    chk("jtag_bootaddr", boot_addr_o, 32'h8000_0080);
    obi(0, 32'h10, 4'hF, 0, 32'd3, 0);
    obi(0, 32'h04, 4'hF, 0, 32'd1, 0);
    obi(1, 32'h00, 4'hF, 32'h0000_1234, 0, 0);
    obi(1, 32'h04, 4'h1, 32'h0, 0, 0);
    chk("run_bootaddr_frozen", boot_addr_o, 32'h8000_0080);
    chk("run_fetch_sticky", fetch_enable_o, 1);
    obi(0, 32'h00, 4'hF, 0, 32'h0000_1234, 0);
    // ---- access errors ----
    obi(0, 32'h14, 4'hF, 0, 0, 1);
    obi(1, 32'h0C, 4'hF, 32'h3, 0, 1);
    obi(0, 32'h02, 4'hF, 0, 0, 1);
    obi(1, 32'h08, 4'h3, 32'h8000_0001, 0, 1);
    obi(1, 32'h10, 4'hF, 32'h5, 0, 1);
    chk("err_no_eoc", eoc_o, 0);
    chk("err_no_exit", exit_code_o, 0);
    obi(0, 32'h10, 4'hF, 0, 32'd3, 0);
    obi(0, 32'h0C, 4'hF, 0, 32'd0, 0);
    // ---- EOC ----
    obi(1, 32'h08, 4'hF, 32'h0000_0007, 0, 0);
    chk("run_exit_only", exit_code_o, 7);
    chk("run_no_eoc", eoc_o, 0);
    obi(1, 32'h08, 4'hF, 32'h8000_002A, 0, 0);
    chk("eoc_flag", eoc_o, 1);
    chk("eoc_exit", exit_code_o, 42);
    obi(0, 32'h10, 4'hF, 0, 32'd4, 0);
    obi(1, 32'h08, 4'hF, 32'h0, 0, 0);
    chk("eoc_hold_flag", eoc_o, 1);
    chk("eoc_hold_exit", exit_code_o, 42);
    chk("eoc_fetch", fetch_enable_o, 1);
    obi(0, 32'h08, 4'hF, 0, 32'h8000_002A, 0);

    // ---- Preloaded boot, exact latency ----
    do_reset("rst_pre", 2'b01);
    wait_fetch(n);
    chk("pre_latency", n, 17);
    chk("pre_bootaddr", boot_addr_o, 32'h0000_1000);
    obi(0, 32'h10, 4'hF, 0, 32'd3, 0);
    obi(0, 32'h0C, 4'hF, 0, 32'd1, 0);

    // ---- mid-RUN reset, then preloaded with BOOTADDR written during DELAY ----
    do_reset("rst_midrun", 2'b01);
    obi(0, 32'h10, 4'hF, 0, 32'd2, 0);
    obi(1, 32'h00, 4'hF, 32'hABCD_0000, 0, 0);
    wait_fetch(n);
    chk("pre2_fetch", fetch_enable_o, 1);
    chk("pre2_bootaddr", boot_addr_o, 32'h0000_1000);
    obi(0, 32'h00, 4'hF, 0, 32'hABCD_0000, 0);

    // ---- mid-DELAY reset resamples changed mode (invalid) ----
    do_reset("rst_pre3", 2'b01);
    repeat (5) @(posedge clk_i);
    obi(0, 32'h10, 4'hF, 0, 32'd2, 0);
    chk("delay_no_fetch", fetch_enable_o, 0);
    do_reset("rst_middelay", 2'b10);
    repeat (3) @(posedge clk_i);
    #1 chk("inv_booterr", boot_err_o, 1);
    obi(0, 32'h10, 4'hF, 0, 32'd5, 0);
    obi(0, 32'h0C, 4'hF, 0, 32'd2, 0);
    obi(1, 32'h04, 4'hF, 32'h1, 0, 0);
    chk("inv_no_fetch", fetch_enable_o, 0);
    obi(0, 32'h04, 4'hF, 0, 32'd0, 0);
    repeat (20) @(posedge clk_i);
    #1 chk("inv_still_no_fetch", fetch_enable_o, 0);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
